// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: one pending-write countdown per register; freezes ID/IF while a source is pending.
// Optional operand bypass on the final countdown cycle is enabled by defining HAZARD_FWD_EN.
module hazard_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CW     = 3,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_wb_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [CW-1:0]     issue_lat,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              is_src2,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              freez,
    output logic              fwd_sel1,
    output logic              fwd_sel2,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    logic [CW-1:0]     cnt_q [NUM_REGS];
    logic [CW-1:0]     cnt_d [NUM_REGS];
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] stall_d;

    logic [CW-1:0] src1_cnt;
    logic [CW-1:0] src2_cnt;
    logic          src1_nz;
    logic          src2_nz;
    logic          haz1;
    logic          haz2;
    logic          accept;

    assign src1_cnt = cnt_q[src1];
    assign src2_cnt = cnt_q[src2];
    assign src1_nz  = (src1 != '0);
    assign src2_nz  = is_src2 && (src2 != '0);

    // Hazard detection; with bypass, an entry one cycle from writeback is forwarded instead of stalled
    always_comb begin
        haz1     = 1'b0;
        haz2     = 1'b0;
        fwd_sel1 = 1'b0;
        fwd_sel2 = 1'b0;
`ifdef HAZARD_FWD_EN
        haz1     = src1_nz && (src1_cnt > CW'(1));
        haz2     = src2_nz && (src2_cnt > CW'(1));
        fwd_sel1 = issue_valid && src1_nz && (src1_cnt == CW'(1));
        fwd_sel2 = issue_valid && src2_nz && (src2_cnt == CW'(1));
`else
        haz1     = src1_nz && (src1_cnt != '0);
        haz2     = src2_nz && (src2_cnt != '0);
`endif
    end

    assign freez  = issue_valid && (haz1 || haz2);
    assign accept = issue_valid && !freez && issue_wb_en && (issue_dest != '0) && !flush;

    // Countdown update: flush clears, mem_stall holds, otherwise decrement; WAW keeps the longer latency
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                if (!mem_stall && (cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] - CW'(1);
                end
                if (accept && (REG_AW'(r) == issue_dest) && (issue_lat > cnt_d[r])) begin
                    cnt_d[r] = issue_lat;
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (freez && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a behavioural countdown model.
module tb_hazard_scoreboard;

    localparam int REG_AW    = 5;
    localparam int CW        = 3;
    localparam int PERF_W    = 8;
    localparam int NREG      = 32;
    localparam int STALL_MAX = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_wb_en = 1'b0;
    logic [REG_AW-1:0] issue_dest = '0;
    logic [CW-1:0]     issue_lat = '0;
    logic [REG_AW-1:0] src1 = '0;
    logic [REG_AW-1:0] src2 = '0;
    logic              is_src2 = 1'b0;
    logic              flush = 1'b0;
    logic              mem_stall = 1'b0;
    logic              freez;
    logic              fwd_sel1;
    logic              fwd_sel2;
    logic [PERF_W-1:0] stall_cycles;

    hazard_scoreboard #(.REG_AW(REG_AW), .CW(CW), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest), .issue_lat(issue_lat), .src1(src1), .src2(src2),
        .is_src2(is_src2), .flush(flush), .mem_stall(mem_stall), .freez(freez),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int m_cnt [NREG];
    int m_stall;
    int total = 0;
    int bad = 0;
    bit last_freez;
    bit last_fwd1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
        m_stall = 0;
    endtask

    // Expected outputs derived from the model's pending counts
    task automatic model_out(output bit f, output bit f1, output bit f2);
        bit h1, h2;
        int c1, c2;
        c1 = m_cnt[int'(src1)];
        c2 = m_cnt[int'(src2)];
`ifdef HAZARD_FWD_EN
        h1 = (src1 != 0) && (c1 > 1);
        h2 = is_src2 && (src2 != 0) && (c2 > 1);
        f1 = issue_valid && (src1 != 0) && (c1 == 1);
        f2 = issue_valid && is_src2 && (src2 != 0) && (c2 == 1);
`else
        h1 = (src1 != 0) && (c1 != 0);
        h2 = is_src2 && (src2 != 0) && (c2 != 0);
        f1 = 1'b0;
        f2 = 1'b0;
`endif
        f = issue_valid && (h1 || h2);
    endtask

    task automatic model_edge(input bit f);
        bit acc;
        int base;
        if (f && m_stall < STALL_MAX) m_stall++;
        acc = issue_valid && !f && issue_wb_en && (issue_dest != 0) && !flush;
        for (int r = 0; r < NREG; r++) begin
            if (flush) m_cnt[r] = 0;
            else begin
                base = mem_stall ? m_cnt[r] : (m_cnt[r] > 0 ? m_cnt[r] - 1 : 0);
                if (acc && r == int'(issue_dest) && int'(issue_lat) > base) base = int'(issue_lat);
                m_cnt[r] = base;
            end
        end
    endtask

    // One clock: drive on negedge, compare before the edge, advance model on the edge
    task automatic cyc(input bit v, input bit wb, input int d, input int lat,
                       input int s1, input int s2, input bit is2, input bit fl, input bit ms);
        bit ef, e1, e2;
        @(negedge clk);
        issue_valid = v; issue_wb_en = wb; issue_dest = REG_AW'(d); issue_lat = CW'(lat);
        src1 = REG_AW'(s1); src2 = REG_AW'(s2); is_src2 = is2; flush = fl; mem_stall = ms;
        #1;
        model_out(ef, e1, e2);
        check("freez", int'(freez), int'(ef));
        check("fwd_sel1", int'(fwd_sel1), int'(e1));
        check("fwd_sel2", int'(fwd_sel2), int'(e2));
        check("stall_cycles", int'(stall_cycles), m_stall);
        last_freez = freez;
        last_fwd1  = fwd_sel1;
        @(posedge clk);
        model_edge(ef);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_freez", int'(freez), 0);
        check("rst_stall", int'(stall_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int exp_n;
        model_clear();
        issue_valid = 1'b1;
        src1 = 5'd3;
        #12;
        check("init_freez", int'(freez), 0);
        check("init_stall", int'(stall_cycles), 0);
        do_reset();

        // Load countdown of 3 on r4, then consume it
        cyc(1, 1, 4, 3, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 4, 0, 0, 0, 0);
            n += int'(last_freez);
`ifdef HAZARD_FWD_EN
            if (i == 2) check("t2_fwd1", int'(last_fwd1), 1);
`endif
        end
`ifdef HAZARD_FWD_EN
        exp_n = 2;
`else
        exp_n = 3;
`endif
        check("t2_freez_cycles", n, exp_n);
        check("t2_freez_after", int'(last_freez), 0);

        // WAW: longer latency wins; non-operand src2 ignored
        cyc(1, 1, 7, 2, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 5, 0, 0, 0, 0, 0);
        check("t3_model_cnt7", m_cnt[7], 5);
        cyc(1, 0, 0, 0, 0, 7, 0, 0, 0);
        check("t3_is2_off", int'(last_freez), 0);
        cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
        check("t3_is2_on", int'(last_freez), 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // mem_stall holds countdown
        cyc(1, 1, 9, 4, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 0, 0, 9, 0, 0, 0, (i < 3) ? 1'b1 : 1'b0);
            n += int'(last_freez);
        end
`ifdef HAZARD_FWD_EN
        exp_n = 6;
`else
        exp_n = 7;
`endif
        check("t4_freez_cycles", n, exp_n);

        // Flush discards pending and same-cycle issue
        cyc(1, 1, 2, 6, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 3, 0, 0, 0, 0, 0);
        cyc(1, 1, 8, 4, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 8, 0, 0, 0, 0);
        check("t5_src8", int'(last_freez), 0);
        cyc(1, 0, 0, 0, 2, 5, 1, 0, 0);
        check("t5_src2_5", int'(last_freez), 0);

        // Randomised traffic on a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0));
        end

        // r0 never pending; stall counter saturates
        do_reset();
        cyc(1, 1, 0, 7, 0, 0, 0, 0, 0);
        check("t6_dest0", int'(last_freez), 0);
        check("t6_model_cnt0", m_cnt[0], 0);
        cyc(1, 1, 3, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 258; i++) cyc(1, 0, 0, 0, 3, 0, 0, 0, 1);
        check("t6_sat", int'(stall_cycles), STALL_MAX);

        // Async reset mid-stall
        do_reset();
        cyc(1, 1, 3, 5, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 3, 0, 0, 0, 0);
        check("t1_pre", int'(last_freez), 1);
        do_reset();
        cyc(1, 0, 0, 0, 3, 0, 0, 0, 0);
        check("t1_after", int'(last_freez), 0);
        check("t1_stall", int'(stall_cycles), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
